i2c_serial_interface: RTL

I2C_SERIAL_INTERFACE -- requirements
Module: i2c_serial_interface

---
 rtl/i2c_slave_pkg.sv | 19 +
 rtl/i2c_serial_interface_scl_edge_det.sv | 21 ++
 rtl/i2c_serial_interface.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared I2C slave definitions: controller state encoding and the default device address.
package i2c_slave_pkg;

  localparam logic [6:0] I2C_ADDRESS_DEFAULT = 7'h3c;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    REG_ADDR,
    REG_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2cState_e;

endpackage

// File: rtl/i2c_serial_interface_scl_edge_det.sv
// Produces one-clk SCL rise/fall pulses by comparing scl against its registered copy.
module scl_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  output logic rise_o,
  output logic fall_o
);

  logic sclQ;

  // Reset to the idle-high level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) sclQ <= 1'b1;
    else     sclQ <= scl_i;
  end

  assign rise_o = scl_i & ~sclQ;
  assign fall_o = ~scl_i & sclQ;

endmodule

// File: rtl/i2c_serial_interface.sv
// I2C register-access slave: address match, register pointer, byte writes and auto-incrementing reads.
module i2c_serial_interface
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] I2C_ADDRESS = I2C_ADDRESS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sdaIn,
  input  logic       startDet,
  input  logic       stopDet,
  input  logic [7:0] rdData,
  output logic [7:0] regAddr,
  output logic [7:0] wrData,
  output logic       writeEn,
  output logic       sdaOut
);

  logic sclRise, sclFall;

  scl_edge_det u_scl_edge_det (
    .clk    (clk),
    .rst    (rst),
    .scl_i  (scl),
    .rise_o (sclRise),
    .fall_o (sclFall)
  );

  i2cState_e  stateQ, stateD;
  logic [2:0] bitCntQ, bitCntD;
  logic [6:0] rxQ, rxD;
  logic [6:0] txQ, txD;
  logic [7:0] regAddrQ, regAddrD;
  logic [7:0] wrDataQ, wrDataD;
  logic       writeEnQ, writeEnD;
  logic       sdaOutQ, sdaOutD;
  logic       rwQ, rwD;
  logic       regValidQ, regValidD;
  logic       ackPhaseQ, ackPhaseD;
  logic [7:0] rxByte;

  assign rxByte = {rxQ, sdaIn};

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= IDLE;
      bitCntQ   <= 3'd0;
      rxQ       <= 7'd0;
      txQ       <= 7'd0;
      regAddrQ  <= 8'h00;
      wrDataQ   <= 8'h00;
      writeEnQ  <= 1'b0;
      sdaOutQ   <= 1'b1;
      rwQ       <= 1'b0;
      regValidQ <= 1'b0;
      ackPhaseQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      bitCntQ   <= bitCntD;
      rxQ       <= rxD;
      txQ       <= txD;
      regAddrQ  <= regAddrD;
      wrDataQ   <= wrDataD;
      writeEnQ  <= writeEnD;
      sdaOutQ   <= sdaOutD;
      rwQ       <= rwD;
      regValidQ <= regValidD;
      ackPhaseQ <= ackPhaseD;
    end
  end

  // ackPhaseQ separates the fall that starts an ACK slot from the fall that ends it.
  always_comb begin
    stateD    = stateQ;
    bitCntD   = bitCntQ;
    rxD       = rxQ;
    txD       = txQ;
    regAddrD  = regAddrQ;
    wrDataD   = wrDataQ;
    writeEnD  = 1'b0;
    sdaOutD   = sdaOutQ;
    rwD       = rwQ;
    regValidD = regValidQ;
    ackPhaseD = ackPhaseQ;

    if (writeEnQ) regAddrD = regAddrQ + 8'd1;

    if (startDet) begin
      stateD    = DEV_ADDR;
      bitCntD   = 3'd0;
      sdaOutD   = 1'b1;
      ackPhaseD = 1'b0;
    end else if (stopDet) begin
      stateD    = IDLE;
      bitCntD   = 3'd0;
      sdaOutD   = 1'b1;
      ackPhaseD = 1'b0;
      regValidD = 1'b0;
    end else begin
      case (stateQ)
        DEV_ADDR: begin
          sdaOutD = 1'b1;
          if (sclRise) begin
            rxD     = rxByte[6:0];
            bitCntD = bitCntQ + 3'd1;
            if (bitCntQ == 3'd7) begin
              if (rxByte[7:1] == I2C_ADDRESS) begin
                stateD    = DEV_ACK;
                rwD       = rxByte[0];
                ackPhaseD = 1'b0;
              end else begin
                stateD = WAIT_STOP;
              end
            end
          end
        end
        DEV_ACK, REG_ACK, WR_ACK: begin
          if (sclFall) begin
            if (!ackPhaseQ) begin
              sdaOutD   = 1'b0;
              ackPhaseD = 1'b1;
            end else begin
              ackPhaseD = 1'b0;
              bitCntD   = 3'd0;
              sdaOutD   = 1'b1;
              if (stateQ == DEV_ACK && rwQ) begin
                stateD  = RD_DATA;
                txD     = rdData[6:0];
                sdaOutD = rdData[7];
              end else if (stateQ == DEV_ACK && !regValidQ) begin
                stateD = REG_ADDR;
              end else begin
                stateD = WR_DATA;
              end
            end
          end
        end
        REG_ADDR: begin
          if (sclRise) begin
            rxD     = rxByte[6:0];
            bitCntD = bitCntQ + 3'd1;
            if (bitCntQ == 3'd7) begin
              regAddrD  = rxByte;
              regValidD = 1'b1;
              stateD    = REG_ACK;
              ackPhaseD = 1'b0;
            end
          end
        end
        WR_DATA: begin
          if (writeEnQ) begin
            stateD    = WR_ACK;
            ackPhaseD = 1'b0;
          end else if (sclRise) begin
            rxD     = rxByte[6:0];
            bitCntD = bitCntQ + 3'd1;
            if (bitCntQ == 3'd7) begin
              wrDataD  = rxByte;
              writeEnD = 1'b1;
            end
          end
        end
        RD_DATA: begin
          if (sclFall) begin
            sdaOutD = txQ[6];
            txD     = {txQ[5:0], 1'b0};
          end
          if (sclRise) begin
            bitCntD = bitCntQ + 3'd1;
            if (bitCntQ == 3'd7) begin
              stateD    = RD_ACK;
              ackPhaseD = 1'b0;
            end
          end
        end
        RD_ACK: begin
          if (sclFall) begin
            if (!ackPhaseQ) begin
              sdaOutD   = 1'b1;
              ackPhaseD = 1'b1;
            end else begin
              ackPhaseD = 1'b0;
              bitCntD   = 3'd0;
              stateD    = RD_DATA;
              txD       = rdData[6:0];
              sdaOutD   = rdData[7];
            end
          end else if (sclRise && ackPhaseQ) begin
            if (sdaIn) begin
              stateD    = WAIT_STOP;
              ackPhaseD = 1'b0;
            end else begin
              regAddrD = regAddrQ + 8'd1;
            end
          end
        end
        default: sdaOutD = 1'b1;
      endcase
    end
  end

  assign regAddr = regAddrQ;
  assign wrData  = wrDataQ;
  assign writeEn = writeEnQ;
  assign sdaOut  = sdaOutQ;

endmodule
